// File: rtl/align_fifo_pack_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// align_fifo_pack_pkg : shared types and pointer helpers for align_* FIFOs
// Revision: 1.0
// ---------------------------------------------------------------------------
package align_fifo_pack_pkg;

  typedef enum logic [1:0] {
    LANE_HOLD  = 2'd0,
    LANE_WRITE = 2'd1,
    LANE_ZERO  = 2'd2
  } lane_op_e;

  localparam int c_PTR_MAX_W = 32;

  // Pointers carry one wrap bit above the slot index.
  function automatic logic ptr_empty(input logic [c_PTR_MAX_W-1:0] head,
                                     input logic [c_PTR_MAX_W-1:0] tail,
                                     input int idx_w);
    logic [c_PTR_MAX_W-1:0] w_mask;
    w_mask = (c_PTR_MAX_W'(1) << (idx_w + 1)) - c_PTR_MAX_W'(1);
    return ((head ^ tail) & w_mask) == '0;
  endfunction

  function automatic logic ptr_full(input logic [c_PTR_MAX_W-1:0] head,
                                    input logic [c_PTR_MAX_W-1:0] tail,
                                    input int idx_w);
    logic [c_PTR_MAX_W-1:0] w_diff;
    logic [c_PTR_MAX_W-1:0] w_imask;
    w_diff  = head ^ tail;
    w_imask = (c_PTR_MAX_W'(1) << idx_w) - c_PTR_MAX_W'(1);
    return ((w_diff & w_imask) == '0) && w_diff[idx_w];
  endfunction

endpackage
`default_nettype wire

// File: rtl/align_fifo_pack_lane_wr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// align_pack_lane_wr : per-lane write / zero-fill decode and word commit
// Revision: 1.0
// ---------------------------------------------------------------------------
module align_pack_lane_wr
  import align_fifo_pack_pkg::*;
#(
  parameter int RATIO = 2,
  parameter int IDX_W = 1
) (
  input  logic             i_accept,
  input  logic             i_last,
  input  logic [IDX_W-1:0] i_sub_idx,
  output lane_op_e         o_lane_op [RATIO],
  output logic             o_commit
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(RATIO - 1);

  assign o_commit = i_accept & (i_last | (i_sub_idx == c_LAST_IDX));

  // Lanes past the current one are cleared when the word closes early.
  for (genvar l = 0; l < RATIO; l++) begin : g_lane
    always_comb begin
      o_lane_op[l] = LANE_HOLD;
      if (i_accept && (i_sub_idx == IDX_W'(l)))
        o_lane_op[l] = LANE_WRITE;
      else if (i_accept && i_last && (IDX_W'(l) > i_sub_idx))
        o_lane_op[l] = LANE_ZERO;
    end
  end

endmodule
`default_nettype wire

// File: rtl/align_fifo_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// align_fifo_pack : packs RATIO subwords (MSB first) into wide FIFO entries
// Optional sticky overflow flag o_err when ALIGN_FIFO_PACK_ERR_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
module align_fifo_pack
  import align_fifo_pack_pkg::*;
#(
  parameter int SUB_W     = 16,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SUB_W-1:0]       i_data,
  input  logic                   i_valid,
  input  logic                   i_last,
  output logic                   o_stall,
  output logic [SUB_W*RATIO-1:0] o_data,
  output logic                   o_last,
  output logic                   o_valid,
  input  logic                   i_stall,
  output logic [LOG_DEPTH:0]     o_level
`ifdef ALIGN_FIFO_PACK_ERR_EN
  ,
  output logic                   o_err
`endif
);

  localparam int c_IDX_W  = $clog2(RATIO);
  localparam int c_WORD_W = SUB_W * RATIO;

  logic [c_WORD_W-1:0]  r_mem      [DEPTH];
  logic                 r_last_mem [DEPTH];
  logic [LOG_DEPTH:0]   r_head;
  logic [LOG_DEPTH:0]   r_tail;
  logic [c_IDX_W-1:0]   r_sub_idx;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_consume;
  logic                 w_commit;
  lane_op_e             w_lane_op [RATIO];
  logic [LOG_DEPTH-1:0] w_head_idx;
  logic [LOG_DEPTH-1:0] w_tail_idx;

  assign w_empty    = ptr_empty(c_PTR_MAX_W'(r_head), c_PTR_MAX_W'(r_tail), LOG_DEPTH);
  assign w_full     = ptr_full(c_PTR_MAX_W'(r_head), c_PTR_MAX_W'(r_tail), LOG_DEPTH);
  assign w_head_idx = r_head[LOG_DEPTH-1:0];
  assign w_tail_idx = r_tail[LOG_DEPTH-1:0];
  assign w_accept   = i_valid & ~w_full;
  assign w_consume  = ~w_empty & ~i_stall;

  assign o_stall = w_full;
  assign o_valid = ~w_empty;
  assign o_level = r_head - r_tail;
  assign o_data  = r_mem[w_tail_idx];
  assign o_last  = r_last_mem[w_tail_idx];

  align_pack_lane_wr #(
    .RATIO (RATIO),
    .IDX_W (c_IDX_W)
  ) u_lane_wr (
    .i_accept  (w_accept),
    .i_last    (i_last),
    .i_sub_idx (r_sub_idx),
    .o_lane_op (w_lane_op),
    .o_commit  (w_commit)
  );

  // Storage is written in place; accept excludes full, so the head slot is never the one being read.
  always_ff @(posedge clk) begin
    for (int l = 0; l < RATIO; l++) begin
      if (w_lane_op[l] == LANE_WRITE)
        r_mem[w_head_idx][(RATIO-l)*SUB_W-1 -: SUB_W] <= i_data;
      else if (w_lane_op[l] == LANE_ZERO)
        r_mem[w_head_idx][(RATIO-l)*SUB_W-1 -: SUB_W] <= '0;
    end
    if (w_commit)
      r_last_mem[w_head_idx] <= i_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_sub_idx <= '0;
    end else begin
      if (w_commit) begin
        r_head    <= r_head + 1'b1;
        r_sub_idx <= '0;
      end else if (w_accept) begin
        r_sub_idx <= r_sub_idx + 1'b1;
      end
      if (w_consume)
        r_tail <= r_tail + 1'b1;
    end
  end

`ifdef ALIGN_FIFO_PACK_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (i_valid && w_full)
      r_err <= 1'b1;
  end
  assign o_err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_align_fifo_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_align_fifo_pack : directed stimulus against a queue-based packing model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_align_fifo_pack;

  localparam int SUB_W     = 16;
  localparam int RATIO     = 2;
  localparam int DEPTH     = 4;
  localparam int LOG_DEPTH = 2;
  localparam int WORD_W    = SUB_W * RATIO;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [SUB_W-1:0]     i_data = '0;
  logic                 i_valid = 1'b0;
  logic                 i_last = 1'b0;
  logic                 i_stall = 1'b0;
  logic                 o_stall;
  logic [WORD_W-1:0]    o_data;
  logic                 o_last;
  logic                 o_valid;
  logic [LOG_DEPTH:0]   o_level;
`ifdef ALIGN_FIFO_PACK_ERR_EN
  logic                 o_err;
`endif

  align_fifo_pack #(
    .SUB_W     (SUB_W),
    .RATIO     (RATIO),
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_stall (o_stall),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_valid (o_valid),
    .i_stall (i_stall),
    .o_level (o_level)
`ifdef ALIGN_FIFO_PACK_ERR_EN
    ,
    .o_err   (o_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of committed words plus the subwords of the open word.
  typedef struct {
    logic [WORD_W-1:0] word;
    logic              last;
  } entry_t;

  entry_t           m_q[$];
  logic [SUB_W-1:0] m_part[$];
  logic             m_err = 1'b0;
  bit               m_live = 1'b0;
  bit               m_in_stream = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_part.delete();
      m_err  = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      bit full;
      full = (m_q.size() == DEPTH);
      if (i_valid && full) m_err = 1'b1;
      if (m_q.size() != 0 && !i_stall) void'(m_q.pop_front());
      if (i_valid && !full) begin
        m_part.push_back(i_data);
        if (i_last || m_part.size() == RATIO) begin
          entry_t e;
          e.word = '0;
          for (int k = 0; k < m_part.size(); k++)
            e.word |= WORD_W'(m_part[k]) << (SUB_W * (RATIO - 1 - k));
          e.last = i_last;
          m_q.push_back(e);
          m_part.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live && !rst) begin
      check("valid", 64'(o_valid), 64'(m_q.size() != 0));
      check("stall", 64'(o_stall), 64'(m_q.size() == DEPTH));
      check("level", 64'(o_level), 64'(m_q.size()));
      if (m_q.size() != 0) begin
        check("data", 64'(o_data), 64'(m_q[0].word));
        check("last", 64'(o_last), 64'(m_q[0].last));
      end
      if (m_in_stream) check("stream_level_le1", 64'(o_level <= 1), 64'(1));
`ifdef ALIGN_FIFO_PACK_ERR_EN
      check("err", 64'(o_err), 64'(m_err));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SUB_W-1:0] d, input logic l);
    int   budget;
    logic acc;
    i_data  = d;
    i_last  = l;
    i_valid = 1'b1;
    budget  = 0;
    forever begin
      acc = ~o_stall;
      tick();
      if (acc) break;
      budget++;
      if (budget > 50) begin
        check("push_timeout", 64'(0), 64'(1));
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // 1: idle after reset
    check("reset_valid", 64'(o_valid), 64'(0));
    check("reset_stall", 64'(o_stall), 64'(0));
    check("reset_level", 64'(o_level), 64'(0));
    repeat (10) tick();

    // 2: two subwords form one word; i_stall holds it at the head
    i_stall = 1'b1;
    push(16'hAAAA, 1'b0);
    push(16'h5555, 1'b0);
    check("t2_data", 64'(o_data), 64'h0000_0000_AAAA_5555);
    check("t2_valid", 64'(o_valid), 64'(1));
    check("t2_last", 64'(o_last), 64'(0));
    check("t2_level", 64'(o_level), 64'(1));
    i_stall = 1'b0;
    tick();

    // 3: early close with zero padding
    i_stall = 1'b1;
    push(16'h1234, 1'b1);
    check("t3_data", 64'(o_data), 64'h0000_0000_1234_0000);
    check("t3_last", 64'(o_last), 64'(1));
    i_stall = 1'b0;
    tick();

    // 4: fill, overflow attempt, one-cycle drain
    i_stall = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      push(16'(16'h1000 + w), 1'b0);
      push(16'(16'h2000 + w), 1'b0);
    end
    check("t4_stall", 64'(o_stall), 64'(1));
    check("t4_level", 64'(o_level), 64'(4));
    check("t4_head", 64'(o_data), 64'h0000_0000_1000_2000);
    i_data  = 16'hDEAD;
    i_valid = 1'b1;
    tick();
`ifdef ALIGN_FIFO_PACK_ERR_EN
    check("t4_err", 64'(o_err), 64'(1));
`endif
    i_stall = 1'b0;
    check("t4_stall_same", 64'(o_stall), 64'(1));
    tick();
    i_stall = 1'b1;
    check("t4_stall_next", 64'(o_stall), 64'(0));
    check("t4_second", 64'(o_data), 64'h0000_0000_1001_2001);
    i_valid = 1'b0;
    i_stall = 1'b0;
    push(16'hBEAD, 1'b1);
    repeat (8) tick();
    check("t4_drained", 64'(o_level), 64'(0));

    // 5: continuous push and pop of 20 words
    m_in_stream = 1'b1;
    for (int w = 0; w < 20; w++) begin
      push(16'(w), 1'b0);
      push(16'(w + 100), 1'b0);
    end
    tick();
    m_in_stream = 1'b0;
    check("t5_empty", 64'(o_valid), 64'(0));

    // 6: reset with a partial word open
    push(16'h7777, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_reset_level", 64'(o_level), 64'(0));
    i_stall = 1'b1;
    push(16'hBEEF, 1'b0);
    push(16'h0001, 1'b0);
    check("t6_data", 64'(o_data), 64'h0000_0000_BEEF_0001);
    i_stall = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
